// File: rtl/stack_queue_buffer.sv
// Parametrised LIFO/FIFO operand store for the stack/queue calculator.
// Circular array with head (oldest), tail (next free) and an occupancy count.
// stackQueue selects stack (0) or queue (1) order; a change of mode flushes the contents.
module stack_queue_buffer #(
   parameter  int unsigned WIDTH = 16,
   parameter  int unsigned DEPTH = 8,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stackQueue,
   input  logic             push,
   input  logic             pop,
   input  logic             clear,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   output logic [WIDTH-1:0] peek,
   output logic [AW:0]      count,
   output logic             empty,
   output logic             full,
   output logic             overflow,
   output logic             underflow
);

   localparam logic [AW:0]   CntFull = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] PtrOne  = AW'(1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_head;
   logic [AW-1:0]    r_tail;
   logic [AW:0]      r_count;
   logic [WIDTH-1:0] r_dout;
   logic             r_dout_valid;
   logic             r_overflow;
   logic             r_underflow;
   logic             r_mode;

   logic [AW-1:0]    w_head_nxt;
   logic [AW-1:0]    w_tail_nxt;
   logic [AW:0]      w_count_nxt;
   logic [WIDTH-1:0] w_dout_nxt;
   logic             w_dout_valid_nxt;
   logic             w_overflow_nxt;
   logic             w_underflow_nxt;
   logic             w_we;
   logic [AW-1:0]    w_waddr;
   logic [AW-1:0]    w_tail_m1;
   logic [AW-1:0]    w_sel_addr;
   logic             w_empty;
   logic             w_full;
   logic             w_mode_chg;

   assign w_empty    = (r_count == '0);
   assign w_full     = (r_count == CntFull);
   assign w_tail_m1  = r_tail - PtrOne;
   // Entry the next pop returns: oldest in queue mode, newest in stack mode
   assign w_sel_addr = r_mode ? r_head : w_tail_m1;
   assign w_mode_chg = (stackQueue != r_mode);

   assign dout       = r_dout;
   assign dout_valid = r_dout_valid;
   assign count      = r_count;
   assign empty      = w_empty;
   assign full       = w_full;
   assign overflow   = r_overflow;
   assign underflow  = r_underflow;
   assign peek       = w_empty ? '0 : r_mem[w_sel_addr];

   // Next-state: clear beats mode change beats push/pop
   always_comb begin
      w_head_nxt       = r_head;
      w_tail_nxt       = r_tail;
      w_count_nxt      = r_count;
      w_dout_nxt       = r_dout;
      w_dout_valid_nxt = 1'b0;
      w_overflow_nxt   = r_overflow;
      w_underflow_nxt  = r_underflow;
      w_we             = 1'b0;
      w_waddr          = r_tail;

      if (clear) begin
         w_head_nxt      = '0;
         w_tail_nxt      = '0;
         w_count_nxt     = '0;
         w_overflow_nxt  = 1'b0;
         w_underflow_nxt = 1'b0;
      end else if (w_mode_chg) begin
         // Flush like clear, but the sticky flags survive
         w_head_nxt  = '0;
         w_tail_nxt  = '0;
         w_count_nxt = '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (w_full) begin
                  w_overflow_nxt = 1'b1;
               end else begin
                  w_we        = 1'b1;
                  w_tail_nxt  = r_tail + PtrOne;
                  w_count_nxt = r_count + 1'b1;
               end
            end
            2'b01: begin
               if (w_empty) begin
                  w_underflow_nxt = 1'b1;
               end else begin
                  w_dout_nxt       = r_mem[w_sel_addr];
                  w_dout_valid_nxt = 1'b1;
                  w_count_nxt      = r_count - 1'b1;
                  if (r_mode) w_head_nxt = r_head + PtrOne;
                  else        w_tail_nxt = w_tail_m1;
               end
            end
            2'b11: begin
               if (w_empty) begin
                  // Nothing to pop: take the push, flag the pop
                  w_underflow_nxt = 1'b1;
                  w_we            = 1'b1;
                  w_tail_nxt      = r_tail + PtrOne;
                  w_count_nxt     = r_count + 1'b1;
               end else if (r_mode) begin
                  // Queue: read oldest and append; works even when full
                  w_dout_nxt       = r_mem[r_head];
                  w_dout_valid_nxt = 1'b1;
                  w_head_nxt       = r_head + PtrOne;
                  w_we             = 1'b1;
                  w_tail_nxt       = r_tail + PtrOne;
               end else begin
                  // Stack: replace the top in place
                  w_dout_nxt       = r_mem[w_tail_m1];
                  w_dout_valid_nxt = 1'b1;
                  w_we             = 1'b1;
                  w_waddr          = w_tail_m1;
               end
            end
            default: ;
         endcase
      end
   end

   // Control and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_head       <= '0;
         r_tail       <= '0;
         r_count      <= '0;
         r_dout       <= '0;
         r_dout_valid <= 1'b0;
         r_overflow   <= 1'b0;
         r_underflow  <= 1'b0;
         r_mode       <= 1'b0;
      end else begin
         r_head       <= w_head_nxt;
         r_tail       <= w_tail_nxt;
         r_count      <= w_count_nxt;
         r_dout       <= w_dout_nxt;
         r_dout_valid <= w_dout_valid_nxt;
         r_overflow   <= w_overflow_nxt;
         r_underflow  <= w_underflow_nxt;
         r_mode       <= stackQueue;
      end
   end

   // Storage array, deliberately left unreset
   always_ff @(posedge clk) begin
      if (w_we) r_mem[w_waddr] <= din;
   end

endmodule

// File: tb/tb_stack_queue_buffer.sv
// Randomised and directed bench for stack_queue_buffer with a queue-based reference model.
// Stimulus updates the model and pushes expected pop data into a scoreboard; a monitor
// compares DUT outputs one step after every rising edge.
module tb_stack_queue_buffer;

   localparam int unsigned WIDTH = 16;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned AW    = $clog2(DEPTH);

   logic             clk = 1'b0;
   logic             rst;
   logic             stackQueue;
   logic             push;
   logic             pop;
   logic             clear;
   logic [WIDTH-1:0] din;
   logic [WIDTH-1:0] dout;
   logic             dout_valid;
   logic [WIDTH-1:0] peek;
   logic [AW:0]      count;
   logic             empty;
   logic             full;
   logic             overflow;
   logic             underflow;

   stack_queue_buffer #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .stackQueue (stackQueue),
      .push       (push),
      .pop        (pop),
      .clear      (clear),
      .din        (din),
      .dout       (dout),
      .dout_valid (dout_valid),
      .peek       (peek),
      .count      (count),
      .empty      (empty),
      .full       (full),
      .overflow   (overflow),
      .underflow  (underflow)
   );

   always #5 clk = ~clk;

   // Reference model: contents oldest-first, plus registered outputs
   logic [WIDTH-1:0] mq[$];
   logic [WIDTH-1:0] exp_q[$];
   logic [WIDTH-1:0] m_dout = '0;
   logic             m_dv   = 1'b0;
   logic             m_ovf  = 1'b0;
   logic             m_unf  = 1'b0;
   logic             m_mode = 1'b0;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] m_peek();
      if (mq.size() == 0) return '0;
      return m_mode ? mq[0] : mq[mq.size()-1];
   endfunction

   // One cycle of stimulus; the model advances to the state after the coming edge
   task automatic step(input logic sq, input logic ps, input logic pp, input logic clr,
                       input logic [WIDTH-1:0] d);
      logic [WIDTH-1:0] v;
      @(negedge clk);
      stackQueue = sq;
      push       = ps;
      pop        = pp;
      clear      = clr;
      din        = d;
      m_dv       = 1'b0;
      if (clr) begin
         mq.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else if (sq != m_mode) begin
         mq.delete();
      end else begin
         if (pp) begin
            if (mq.size() == 0) begin
               m_unf = 1'b1;
            end else begin
               v = m_mode ? mq.pop_front() : mq.pop_back();
               m_dout = v;
               m_dv   = 1'b1;
               exp_q.push_back(v);
            end
         end
         if (ps) begin
            if (mq.size() < DEPTH) mq.push_back(d);
            else                   m_ovf = 1'b1;
         end
      end
      m_mode = sq;
   endtask

   task automatic do_push(input logic sq, input logic [WIDTH-1:0] d);
      step(sq, 1'b1, 1'b0, 1'b0, d);
   endtask

   task automatic do_pop(input logic sq);
      step(sq, 1'b0, 1'b1, 1'b0, '0);
   endtask

   task automatic do_idle(input logic sq);
      step(sq, 1'b0, 1'b0, 1'b0, '0);
   endtask

   // Asynchronous reset from wherever the caller currently is in the cycle
   task automatic do_reset();
      rst        = 1'b1;
      push       = 1'b0;
      pop        = 1'b0;
      clear      = 1'b0;
      stackQueue = 1'b0;
      mq.delete();
      exp_q.delete();
      m_dout = '0;
      m_dv   = 1'b0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
      m_mode = 1'b0;
      #1;
      chk("rst_async_dout", 32'(dout), 32'h0);
      chk("rst_async_dout_valid", 32'(dout_valid), 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Monitor: state checks every cycle, scoreboard pop on every dout_valid pulse
   always @(posedge clk) begin
      logic [WIDTH-1:0] e;
      #1;
      chk("count", 32'(count), 32'(mq.size()));
      chk("empty", 32'(empty), 32'(mq.size() == 0));
      chk("full", 32'(full), 32'(mq.size() == DEPTH));
      chk("peek", 32'(peek), 32'(m_peek()));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("underflow", 32'(underflow), 32'(m_unf));
      chk("dout", 32'(dout), 32'(m_dout));
      chk("dout_valid", 32'(dout_valid), 32'(m_dv));
      if (dout_valid) begin
         if (exp_q.size() == 0) begin
            chk("sb_spurious_valid", 32'(dout), 32'hDEAD_BEEF);
         end else begin
            e = exp_q.pop_front();
            chk("sb_data", 32'(dout), 32'(e));
         end
      end
   end

   initial begin
      logic       rsq;
      logic       rclr;
      logic       rps;
      logic       rpp;
      int         r;
      rst        = 1'b1;
      stackQueue = 1'b0;
      push       = 1'b0;
      pop        = 1'b0;
      clear      = 1'b0;
      din        = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      do_idle(1'b0);

      // Stack order
      do_push(1'b0, 16'hF0F0);
      do_push(1'b0, 16'hE4E4);
      do_push(1'b0, 16'h1234);
      repeat (3) do_pop(1'b0);
      do_idle(1'b0);

      // Queue fill, overflow, drain across wrap, underflow
      do_idle(1'b1);
      for (int i = 1; i <= 8; i++) do_push(1'b1, 16'(i));
      do_push(1'b1, 16'h0009);
      repeat (8) do_pop(1'b1);
      do_pop(1'b1);
      do_idle(1'b1);

      // Queue full: simultaneous push and pop
      for (int i = 1; i <= 8; i++) do_push(1'b1, 16'(i));
      step(1'b1, 1'b1, 1'b1, 1'b0, 16'hAAAA);
      repeat (8) do_pop(1'b1);
      do_idle(1'b1);

      // Stack replace-top
      do_idle(1'b0);
      do_push(1'b0, 16'h0005);
      do_push(1'b0, 16'h0006);
      step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0009);
      do_idle(1'b0);
      // Overflow on a stack too, then mode toggle keeps flags, clear drops them
      for (int i = 0; i < 7; i++) do_push(1'b0, 16'(16'h0100 + i));
      do_push(1'b0, 16'h0BAD);
      do_idle(1'b1);
      do_idle(1'b1);
      step(1'b1, 1'b1, 1'b1, 1'b1, 16'h7777);
      do_idle(1'b1);

      // Reset during a pending pop: the pop must be aborted
      do_idle(1'b0);
      do_push(1'b0, 16'h0C0C);
      do_push(1'b0, 16'h0D0D);
      do_pop(1'b0);
      #2;
      do_reset();
      // Reset while dout_valid is high: dout drops immediately
      do_push(1'b0, 16'h5A5A);
      do_pop(1'b0);
      @(posedge clk);
      #3;
      do_reset();

      // Random traffic
      rsq = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         r    = int'($urandom_range(0, 99));
         rclr = (r >= 97);
         if (r < 2) rsq = ~rsq;
         rps  = ($urandom_range(0, 99) < 55);
         rpp  = ($urandom_range(0, 99) < 45);
         step(rsq, rps, rpp, rclr, 16'($urandom));
      end
      repeat (3) do_idle(rsq);

      chk("sb_drain", 32'(exp_q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/stack_queue_buffer.md
Name: stack_queue_buffer

Overview:
- Parametrised LIFO/FIFO storage core for the stack/queue calculator datapath. It holds operands entered from the switches and returns them to the ALU in stack (LIFO) or queue (FIFO) order, selected at run time by stackQueue.
- It supersedes the fixed 16-bit single-depth storage with configurable width and depth, an occupancy count, peek, error flags and simultaneous push/pop.
- It sits between the debounced-button controller, which supplies push/pop/clear pulses, and the operand/result path.

Parameters:
- WIDTH, 16, data word width in bits.
- DEPTH, 8, number of entries; must be a power of two and at least 2.
- AW, $clog2(DEPTH), pointer width (derived; not overridden).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- stackQueue  in  1  mode select: 0 = stack (LIFO), 1 = queue (FIFO).
- push  in  1  single-cycle write request.
- pop  in  1  single-cycle read request.
- clear  in  1  synchronous flush.
- din  in  WIDTH  write data.
- dout  out  WIDTH  registered read data.
- dout_valid  out  1  one-cycle pulse, high the cycle after an accepted pop.
- peek  out  WIDTH  combinational view of the entry the next pop would return; 0 when empty.
- count  out  AW+1  number of stored entries, 0..DEPTH.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- overflow  out  1  sticky; set on a rejected push.
- underflow  out  1  sticky; set on a rejected pop.

Behaviour:
- Storage and pointers:
  - Circular array mem[DEPTH] with head pointer (oldest entry), tail pointer (next free slot) and count register.
  - Pointers wrap modulo DEPTH.
- Reset (rst=1, asynchronous):
  - head=0, tail=0, count=0.
  - dout=0, dout_valid=0, overflow=0, underflow=0, mode register=0.
  - Memory contents are not reset.
- Priority each cycle: clear > mode change > push/pop.
- clear:
  - head=tail=count=0, dout_valid=0, overflow=underflow=0.
  - dout holds its value. push/pop in the same cycle are ignored.
- Mode change:
  - stackQueue is registered internally (mode_q).
  - If stackQueue != mode_q, the buffer flushes exactly as for clear, except the sticky flags are kept. mode_q updates that cycle; push/pop in that cycle are ignored.
- Push alone:
  - If not full: mem[tail]=din, tail+1, count+1.
  - If full: no state change, overflow<=1.
- Pop alone:
  - If not empty: next cycle dout=selected entry and dout_valid=1.
    - Queue: selected entry is mem[head]; head+1.
    - Stack: selected entry is mem[tail-1]; tail-1.
    - count-1 in both modes.
  - If empty: dout unchanged, dout_valid=0, underflow<=1.
- Push and pop together, queue mode:
  - empty: the push is accepted, the pop is rejected, underflow<=1.
  - Otherwise, including full: both are accepted. dout=mem[head], head+1, mem[tail]=din, tail+1, count unchanged.
- Push and pop together, stack mode:
  - empty: the push is accepted, the pop is rejected, underflow<=1.
  - Otherwise (replace-top): dout=mem[tail-1], mem[tail-1]=din, pointers and count unchanged.
- peek:
  - Queue: mem[head]. Stack: mem[tail-1]. 0 if empty.
- Latency:
  - A push is visible on peek and count the cycle after it is accepted.
  - dout is valid one cycle after pop.
- Sticky flags are cleared only by rst or clear.
- Reset asserted mid-operation aborts any pending pop; dout_valid is 0 while rst is high.

Test Plan:
- Reset, then idle: count=0, empty=1, full=0, dout=0, peek=0, no flags set.
- Stack mode (WIDTH=16, DEPTH=8): push F0F0, E4E4, 1234, then pop three times -> dout 1234, E4E4, F0F0, each with a dout_valid pulse; then empty=1.
- Queue mode: push 0001..0008 -> full=1, count=8. Push 0009 -> overflow=1, count stays 8. Pop eight times -> 0001..0008 in order, with pointers having wrapped. A further pop -> underflow=1, dout_valid=0.
- Queue full, with 0001..0008 stored: push AAAA and pop in the same cycle -> dout=0001, count=8. Peek then shows 0002. Popping all eight returns 0002..0008, then AAAA.
- Stack holding 0005, 0006: push 0009 and pop in the same cycle -> dout=0006, count=2, peek=0009.
- Stack holding 3 entries: toggle stackQueue -> count=0, empty=1, sticky flags kept. Then assert clear -> flags clear. Assert rst mid-pop -> dout_valid=0 and dout=0 immediately (asynchronous).
